// File: rtl/ip_mapper_pkg.sv
// Shared definitions for the MSX memory-mapper RAM bridge: FSM state
// encoding, power-on segment values and the default I/O port base.
package ip_mapper_pkg;

    // PSRAM request sequencing states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_DATA = 2'd2
    } mapper_state_t;

    // Power-on segment per page: page 0 -> 3, page 1 -> 2, page 2 -> 1, page 3 -> 0.
    // Stored 8 bits wide; the register file keeps only the low SEG_BITS.
    localparam logic [7:0] MAPPER_RESET_SEG [0:3] = '{8'h03, 8'h02, 8'h01, 8'h00};

    // First of the four consecutive segment ports (FCh..FFh)
    localparam logic [7:0] IO_BASE_DEFAULT = 8'hFC;

    // Each segment spans 16KB
    localparam int SEG_OFFSET_BITS = 14;

endpackage

// File: rtl/ip_mapper_segreg.sv
// Four segment registers, one per 16KB CPU page. One write port driven by
// the I/O decode, two asynchronous read ports: one selected by the CPU page
// of the current memory cycle, one selected by the I/O port for read-back.
module ip_mapper_segreg
    import ip_mapper_pkg::*;
#(
    parameter int SEG_BITS = 7
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                we,
    input  logic [1:0]          waddr,
    input  logic [SEG_BITS-1:0] wdata,
    input  logic [1:0]          page_sel,
    output logic [SEG_BITS-1:0] page_seg,
    input  logic [1:0]          io_sel,
    output logic [SEG_BITS-1:0] io_seg
);

    logic [SEG_BITS-1:0] seg [0:3];

    // Register file: load power-on map on reset, otherwise take I/O writes
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < 4; i++) begin
                seg[i] <= MAPPER_RESET_SEG[i][SEG_BITS-1:0];
            end
        end else if (we) begin
            seg[waddr] <= wdata;
        end
    end

    assign page_seg = seg[page_sel];
    assign io_seg   = seg[io_sel];

endmodule

// File: rtl/ip_mapper_ram.sv
// MSX memory-mapper RAM bridge. Maps the 64KB CPU space onto a PSRAM region
// through four I/O-programmable 16KB segment registers and turns single-cycle
// bus strobes into held PSRAM requests (request / accept / data).
module ip_mapper_ram
    import ip_mapper_pkg::*;
#(
    parameter int                   SEG_BITS  = 7,
    parameter int                   ADDR_BITS = 22,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR = '0,
    parameter logic [7:0]           IO_BASE   = IO_BASE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 n_reset,
    // MSX-50BUS slave side
    input  logic [15:0]          bus_address,
    output logic                 bus_io_cs,
    output logic                 bus_memory_cs,
    output logic                 bus_read_ready,
    output logic [7:0]           bus_read_data,
    input  logic [7:0]           bus_write_data,
    input  logic                 bus_read,
    input  logic                 bus_write,
    input  logic                 bus_io,
    input  logic                 bus_memory,
    // PSRAM controller request port
    output logic                 rd,
    output logic                 wr,
    input  logic                 busy,
    output logic [ADDR_BITS-1:0] address,
    output logic [7:0]           wdata,
    input  logic [7:0]           rdata,
    input  logic                 rdata_en
);

    localparam int OFS_W = SEG_BITS + SEG_OFFSET_BITS;
    localparam int SUM_W = OFS_W + ADDR_BITS;

    mapper_state_t         state;
    mapper_state_t         state_nxt;
    logic                  op_write;
    logic                  accept_op;
    logic                  mem_data_due;

    logic                  io_hit;
    logic                  seg_we;
    logic                  io_read_due;
    logic                  mem_rd_req;
    logic                  mem_wr_req;
    logic [SEG_BITS-1:0]   page_seg;
    logic [SEG_BITS-1:0]   io_seg;
    logic [7:0]            io_word;
    logic [SUM_W-1:0]      map_sum;
    logic [ADDR_BITS-1:0]  mapped_addr;

    // Bus decode: the mapper owns the whole memory slot, I/O only on its four ports
    assign io_hit        = bus_io && (bus_address[7:2] == IO_BASE[7:2]);
    assign bus_io_cs     = io_hit;
    assign bus_memory_cs = bus_memory;

    assign seg_we      = io_hit && bus_write;
    assign io_read_due = io_hit && bus_read;
    assign mem_rd_req  = bus_memory && bus_read;
    assign mem_wr_req  = bus_memory && bus_write;

    ip_mapper_segreg #(
        .SEG_BITS (SEG_BITS)
    ) u_segreg (
        .clk      (clk),
        .n_reset  (n_reset),
        .we       (seg_we),
        .waddr    (bus_address[1:0]),
        .wdata    (bus_write_data[SEG_BITS-1:0]),
        .page_sel (bus_address[15:14]),
        .page_seg (page_seg),
        .io_sel   (bus_address[1:0]),
        .io_seg   (io_seg)
    );

    // Physical address: wide sum so the carry is visible, then wrap to ADDR_BITS
    assign map_sum     = {{ADDR_BITS{1'b0}}, page_seg, bus_address[SEG_OFFSET_BITS-1:0]}
                       + {{OFS_W{1'b0}}, BASE_ADDR};
    assign mapped_addr = map_sum[ADDR_BITS-1:0];

    // Read-back word: unused upper bits read as 1
    always_comb begin
        io_word                = 8'hFF;
        io_word[SEG_BITS-1:0]  = io_seg;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; memory strobes are only taken in IDLE
    always_comb begin
        state_nxt    = state;
        accept_op    = 1'b0;
        mem_data_due = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_rd_req || mem_wr_req) begin
                    accept_op = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!busy) begin
                    state_nxt = op_write ? ST_IDLE : ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (rdata_en) begin
                    mem_data_due = 1'b1;
                    state_nxt    = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Requests are held for the whole REQ state and drop on the accepting edge
    assign rd = (state == ST_REQ) && !op_write;
    assign wr = (state == ST_REQ) &&  op_write;

    // Latch address, direction and write data when a strobe is accepted so
    // later segment writes cannot disturb an operation already in flight
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            address  <= '0;
            wdata    <= 8'h00;
            op_write <= 1'b0;
        end else if (accept_op) begin
            address  <= mapped_addr;
            op_write <= !mem_rd_req;
            if (!mem_rd_req) begin
                wdata <= bus_write_data;
            end
        end
    end

    // Bus read response: single-cycle ready, data forced to 0 otherwise;
    // memory data takes precedence over an I/O read-back
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            bus_read_ready <= 1'b0;
            bus_read_data  <= 8'h00;
        end else if (mem_data_due) begin
            bus_read_ready <= 1'b1;
            bus_read_data  <= rdata;
        end else if (io_read_due) begin
            bus_read_ready <= 1'b1;
            bus_read_data  <= io_word;
        end else begin
            bus_read_ready <= 1'b0;
            bus_read_data  <= 8'h00;
        end
    end

endmodule

// File: tb/tb_ip_mapper_ram.sv
// Bench for ip_mapper_ram: directed scenarios followed by random bus traffic.
// A reference mapper (segment array + memory array) predicts PSRAM requests
// and bus read data; a PSRAM model and a bus monitor compare against queues.
module tb_ip_mapper_ram;

    localparam int         SEG_BITS  = 7;
    localparam int         ADDR_BITS = 22;
    localparam logic [21:0] BASE     = 22'h300000;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] bus_address;
    logic        bus_io_cs, bus_memory_cs, bus_read_ready;
    logic [7:0]  bus_read_data, bus_write_data;
    logic        bus_read, bus_write, bus_io, bus_memory;
    logic        rd, wr, busy;
    logic [21:0] address;
    logic [7:0]  wdata, rdata;
    logic        rdata_en;

    always #5 clk = ~clk;

    ip_mapper_ram #(
        .SEG_BITS  (SEG_BITS),
        .ADDR_BITS (ADDR_BITS),
        .BASE_ADDR (BASE),
        .IO_BASE   (8'hFC)
    ) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .bus_address    (bus_address),
        .bus_io_cs      (bus_io_cs),
        .bus_memory_cs  (bus_memory_cs),
        .bus_read_ready (bus_read_ready),
        .bus_read_data  (bus_read_data),
        .bus_write_data (bus_write_data),
        .bus_read       (bus_read),
        .bus_write      (bus_write),
        .bus_io         (bus_io),
        .bus_memory     (bus_memory),
        .rd             (rd),
        .wr             (wr),
        .busy           (busy),
        .address        (address),
        .wdata          (wdata),
        .rdata          (rdata),
        .rdata_en       (rdata_en)
    );

    typedef struct {
        bit          is_wr;
        logic [21:0] addr;
        logic [7:0]  data;
    } req_t;

    req_t       exp_req [$];
    logic [7:0] exp_rd  [$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         outstanding = 0;

    logic [6:0] ref_seg   [4];
    logic [7:0] ref_mem   [int];
    logic [7:0] psram_mem [int];

    int  busy_hold       = 0;
    bit  rand_busy       = 0;
    int  rd_delay_fix    = 0;
    bit  force_rden      = 0;
    int  last_req_cycles = 0;
    int  req_cycles      = 0;
    int  rd_sched        = 0;
    logic [7:0] pend_rdata;
    logic [7:0] mon_e;
    req_t       h;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] dflt(int a);
        return a[7:0] ^ a[15:8] ^ a[23:16];
    endfunction

    // Mapping rule in plain arithmetic: base + segment * 16KB + offset, mod 4MB
    function automatic int map_addr(logic [15:0] a);
        longint s;
        s = longint'(BASE) + longint'(ref_seg[a[15:14]]) * 16384 + longint'(a[13:0]);
        return int'(s % (longint'(1) << 22));
    endfunction

    task automatic reset_model();
        ref_seg[0] = 7'd3; ref_seg[1] = 7'd2; ref_seg[2] = 7'd1; ref_seg[3] = 7'd0;
    endtask

    // Bus monitor: every ready pulse must match the oldest expected read
    initial begin
        forever begin
            @(negedge clk);
            if (bus_read_ready) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_ready", 32'(bus_read_ready), 32'd0);
                end else begin
                    mon_e = exp_rd.pop_front();
                    check("read_data", 32'(bus_read_data), 32'(mon_e));
                    outstanding--;
                end
            end else begin
                check("idle_data_zero", 32'(bus_read_data), 32'd0);
            end
        end
    end

    // PSRAM model: drives busy/rdata, checks each pending request cycle
    initial begin
        busy = 1'b0; rdata_en = 1'b0; rdata = 8'h00;
        forever begin
            @(negedge clk);
            rdata_en = 1'b0;
            if (rd_sched > 0) begin
                rd_sched--;
                if (rd_sched == 0) begin
                    rdata_en = 1'b1;
                    rdata    = pend_rdata;
                end
            end
            if (force_rden) begin
                rdata_en   = 1'b1;
                rdata      = 8'h5A;
                force_rden = 1'b0;
            end
            if ((rd || wr) && busy_hold > 0) begin
                busy = 1'b1;
                busy_hold--;
            end else if (rand_busy) begin
                busy = ($urandom_range(0, 2) == 0);
            end else begin
                busy = 1'b0;
            end
            if (rd || wr) begin
                req_cycles++;
                if (exp_req.size() == 0) begin
                    check("unexpected_req", 32'({rd, wr}), 32'd0);
                end else begin
                    h = exp_req[0];
                    check("req_type", 32'({rd, wr}), h.is_wr ? 32'd1 : 32'd2);
                    check("req_addr", 32'(address), 32'(h.addr));
                    if (h.is_wr) check("req_wdata", 32'(wdata), 32'(h.data));
                    if (!busy) begin
                        h = exp_req.pop_front();
                        last_req_cycles = req_cycles;
                        req_cycles = 0;
                        if (h.is_wr) begin
                            psram_mem[int'(address)] = wdata;
                            outstanding--;
                        end else begin
                            pend_rdata = psram_mem.exists(int'(address)) ?
                                         psram_mem[int'(address)] : dflt(int'(address));
                            rd_sched = (rd_delay_fix > 0) ? rd_delay_fix : int'($urandom_range(1, 4));
                        end
                    end
                end
            end
        end
    end

    task automatic drive_idle();
        bus_read = 1'b0; bus_write = 1'b0; bus_io = 1'b0; bus_memory = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (outstanding != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (outstanding != 0) begin
            check("timeout_outstanding", 32'(outstanding), 32'd0);
            outstanding = 0;
            exp_req.delete();
            exp_rd.delete();
        end
        @(negedge clk);
    endtask

    task automatic io_write(logic [7:0] port, logic [7:0] d);
        bit hit = (port[7:2] == 6'h3F);
        @(negedge clk);
        bus_address = {8'($urandom), port};
        bus_io = 1'b1; bus_write = 1'b1; bus_write_data = d;
        #1;
        check("io_cs_wr", 32'(bus_io_cs), 32'(hit));
        check("mem_cs_io", 32'(bus_memory_cs), 32'd0);
        if (hit) ref_seg[port[1:0]] = d[6:0];
        @(negedge clk);
        drive_idle();
    endtask

    task automatic io_read(logic [7:0] port);
        bit hit = (port[7:2] == 6'h3F);
        @(negedge clk);
        bus_address = {8'($urandom), port};
        bus_io = 1'b1; bus_read = 1'b1;
        #1;
        check("io_cs_rd", 32'(bus_io_cs), 32'(hit));
        if (hit) begin
            exp_rd.push_back({1'b1, ref_seg[port[1:0]]});
            outstanding++;
        end
        @(negedge clk);
        drive_idle();
        wait_idle();
    endtask

    task automatic mem_write(logic [15:0] a, logic [7:0] d, bit drop);
        req_t r;
        @(negedge clk);
        bus_address = a; bus_memory = 1'b1; bus_write = 1'b1; bus_write_data = d;
        #1;
        check("mem_cs", 32'(bus_memory_cs), 32'd1);
        check("io_cs_mem", 32'(bus_io_cs), 32'd0);
        if (!drop) begin
            r.is_wr = 1'b1; r.addr = 22'(map_addr(a)); r.data = d;
            exp_req.push_back(r);
            ref_mem[map_addr(a)] = d;
            outstanding++;
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic mem_read(logic [15:0] a);
        req_t r;
        int   pa;
        @(negedge clk);
        bus_address = a; bus_memory = 1'b1; bus_read = 1'b1;
        #1;
        check("mem_cs", 32'(bus_memory_cs), 32'd1);
        pa = map_addr(a);
        r.is_wr = 1'b0; r.addr = 22'(pa); r.data = 8'h00;
        exp_req.push_back(r);
        exp_rd.push_back(ref_mem.exists(pa) ? ref_mem[pa] : dflt(pa));
        outstanding++;
        @(negedge clk);
        drive_idle();
    endtask

    // Main stimulus
    initial begin
        int old_pa;
        int pa;
        drive_idle();
        bus_address = 16'h0000; bus_write_data = 8'h00;
        reset_model();
        repeat (3) @(negedge clk);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_ready", 32'(bus_read_ready), 32'd0);
        n_reset = 1'b1;

        // Power-on segment read-back
        for (int p = 0; p < 4; p++) io_read(8'hFC + 8'(p));

        // Paged write, accepted immediately
        io_write(8'hFE, 8'h05);
        mem_write(16'h8123, 8'hA5, 1'b0);
        wait_idle();
        check("wr_one_cycle", 32'(last_req_cycles), 32'd1);
        check("wr_addr_const", 32'(address), 32'(BASE + 22'h14123));

        // Read held off by busy for three cycles
        pa = map_addr(16'h4000);
        ref_mem[pa] = 8'h3C; psram_mem[pa] = 8'h3C;
        busy_hold = 3; rd_delay_fix = 2;
        mem_read(16'h4000);
        wait_idle();
        check("rd_held_cycles", 32'(last_req_cycles), 32'd4);

        // Segment write and a memory strobe while a read is in flight
        busy_hold = 3; rd_delay_fix = 6;
        old_pa = map_addr(16'hC000);
        mem_read(16'hC000);
        io_write(8'hFF, 8'h10);
        mem_write(16'h0000, 8'h77, 1'b1);
        wait_idle();
        check("inflight_addr", 32'(address), 32'(old_pa));
        rd_delay_fix = 0;
        mem_read(16'hC000);
        wait_idle();
        check("new_seg_addr", 32'(address), 32'(BASE + 22'h040000));

        // Full-width segment and address wrap
        io_write(8'hFC, 8'hFF);
        io_read(8'hFC);
        mem_read(16'h0000);
        wait_idle();
        check("wrap_addr", 32'(address), 32'h0FC000);

        // Reset in the middle of a held request
        busy_hold = 1000;
        mem_read(16'h2000);
        @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        check("reset_drops_rd", 32'(rd), 32'd0);
        exp_req.delete(); exp_rd.delete();
        outstanding = 0; busy_hold = 0; req_cycles = 0;
        reset_model();
        force_rden = 1'b1;
        repeat (6) @(negedge clk);
        check("after_reset_ready", 32'(bus_read_ready), 32'd0);
        io_read(8'hFD);

        // Random traffic
        rand_busy = 1'b1;
        repeat (250) begin
            int   op;
            logic [7:0]  port;
            logic [15:0] a;
            op   = int'($urandom_range(0, 9));
            port = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFC + 8'($urandom_range(0, 3));
            a    = {2'($urandom_range(0, 3)), 14'($urandom_range(0, 31))};
            if (op <= 2) begin
                io_write(port, 8'($urandom));
            end else if (op <= 4) begin
                io_read(port);
            end else if (op <= 6) begin
                mem_write(a, 8'($urandom), 1'b0);
                wait_idle();
            end else begin
                mem_read(a);
                if ($urandom_range(0, 3) == 0) io_write(8'hFC + 8'($urandom_range(0, 3)), 8'($urandom));
                wait_idle();
            end
        end

        wait_idle();
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
